// File: rtl/fetch_queue_if.sv
// Fetch queue shared types and the fetch/decode handshake bundle.
package fetch_queue_pkg;

    // One completed instruction fetch as handed from fetch to decode.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic [7:0]  ex;
    } fetch_data_t;

endpackage

// Handshake bundle between fetch (master side) and the fetch queue (slave side).
// Decode-side signals live here too so the queue has a single bus port.
interface fetch_queue_if #(
    parameter int DEPTH = 2
) ();
    import fetch_queue_pkg::*;

    logic                     flush;
    logic                     fetch_pending;
    logic                     in_valid;
    fetch_data_t              in_data;
    logic                     in_ready;
    logic                     out_valid;
    fetch_data_t              out_data;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, fetch_pending, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, fetch_pending, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO between fetch and decode, with a
// small state machine that discards the one stale ibus response still in
// flight after a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        NORMAL = 1'b0,
        DROP   = 1'b1
    } drop_state_t;

    fetch_data_t        mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    drop_state_t        state;
    drop_state_t        state_next;

    logic               in_ready;
    logic               out_valid;
    logic               drop;
    logic               push;
    logic               pop;

    // Handshake flags come from registered state only, so a pop cannot free
    // a slot for a push in the same cycle.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);

    // The first response after a redirect with a pending request is stale.
    assign drop = (state == DROP) & bus.in_valid;
    assign push = bus.in_valid & in_ready & ~bus.flush & ~drop;
    assign pop  = out_valid & bus.out_ready & ~bus.flush;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem[rd_ptr] : '0;
    assign bus.count     = count;

    // Entry storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Pointers and occupancy; flush empties the queue, reset wins over all.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drop state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // Drop next-state: arm on a redirect that leaves a request outstanding,
    // disarm once the stale response has been swallowed.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL: begin
                if (bus.flush && bus.fetch_pending) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.in_valid) begin
                    if (bus.flush && bus.fetch_pending) state_next = DROP;
                    else                                state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table of per-cycle vectors with
// expected occupancy, a scoreboard for popped data, and hand-written reset
// sequences.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic          iv;
        logic [63:0]   pc;
        logic          fl;
        logic          fp;
        logic          ordy;
        logic          acc;   // entry expected to be pushed this cycle
        logic [CW-1:0] cnt;   // expected count after the edge
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          checks = 0;
    int          fails  = 0;
    fetch_data_t sb [$];
    vec_t        vecs [$];

    function automatic fetch_data_t mk(input logic [63:0] pc);
        fetch_data_t d;
        d.pc        = pc;
        d.raw_instr = pc[31:0] ^ 32'h0000_0013;
        d.ex        = pc[9:2];
        return d;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [63:0] pc, input logic fl, input logic fp,
                       input logic ordy, input logic acc, input int cnt);
        vec_t v;
        v.iv = iv; v.pc = pc; v.fl = fl; v.fp = fp; v.ordy = ordy; v.acc = acc;
        v.cnt = CW'(cnt);
        vecs.push_back(v);
    endtask

    task automatic check_state(input string tag, input logic [CW-1:0] cnt);
        chk({tag, "_count"},     bus.count,     cnt);
        chk({tag, "_in_ready"},  bus.in_ready,  cnt != CW'(DEPTH));
        chk({tag, "_out_valid"}, bus.out_valid, cnt != '0);
        if (cnt == '0) chk({tag, "_out_data_zero"}, bus.out_data, '0);
    endtask

    // Drive one vector mid-cycle, check any pop against the scoreboard,
    // then check occupancy after the edge.
    task automatic run(input vec_t v, input int idx);
        fetch_data_t e;
        bus.in_valid      = v.iv;
        bus.in_data       = v.iv ? mk(v.pc) : '0;
        bus.flush         = v.fl;
        bus.fetch_pending = v.fp;
        bus.out_ready     = v.ordy;
        #1;
        if (bus.out_valid && v.ordy && !v.fl) begin
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_pop_when_empty", idx), bus.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_pop_data", idx), bus.out_data, e);
            end
        end
        @(posedge clk);
        #1;
        if (v.fl)  sb.delete();
        if (v.acc) sb.push_back(mk(v.pc));
        check_state($sformatf("v%0d", idx), v.cnt);
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0;
        bus.fetch_pending = 1'b0; bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        // iv pc fl fp ordy acc cnt
        // Basic flow with decode ready; empty queue ignores out_ready
        add(1, 64'h8000_0000, 0, 0, 1, 1, 1);
        add(1, 64'h8000_0004, 0, 0, 1, 1, 1);
        add(0, 64'h0,         0, 0, 1, 0, 0);
        // Full / backpressure
        add(1, 64'h8000_0000, 0, 0, 0, 1, 1);
        add(1, 64'h8000_0004, 0, 0, 0, 1, 2);
        add(1, 64'h8000_0008, 0, 0, 0, 0, 2);
        add(1, 64'h8000_0008, 0, 0, 1, 0, 1);   // full: pop does not free slot this cycle
        add(0, 64'h0,         0, 0, 1, 0, 0);
        // Wrap: push+pop every cycle at count=1
        add(1, 64'h0000_1000, 0, 0, 1, 1, 1);
        for (int k = 1; k <= 10; k++) add(1, 64'h0000_1000 + 64'(4 * k), 0, 0, 1, 1, 1);
        add(0, 64'h0,         0, 0, 1, 0, 0);
        // Flush with pending fetch: stale response dropped
        add(1, 64'h8000_0000, 0, 0, 0, 1, 1);
        add(1, 64'h8000_0004, 0, 0, 0, 1, 2);
        add(0, 64'h0,         1, 1, 1, 0, 0);
        add(0, 64'h0,         0, 1, 1, 0, 0);
        add(1, 64'h8000_0008, 0, 0, 0, 0, 0);
        add(1, 64'h8000_0100, 0, 0, 0, 1, 1);
        add(0, 64'h0,         0, 0, 1, 0, 0);
        // Flush without pending fetch, simultaneous in_valid discarded
        add(1, 64'h8000_0200, 0, 0, 0, 1, 1);
        add(1, 64'h8000_0204, 1, 0, 0, 0, 0);
        add(1, 64'h8000_0208, 0, 0, 0, 1, 1);
        add(0, 64'h0,         0, 0, 1, 0, 0);
        // DROP, then flush+in_valid with nothing pending returns to NORMAL
        add(0, 64'h0,         1, 1, 0, 0, 0);
        add(1, 64'h8000_0300, 1, 0, 0, 0, 0);
        add(1, 64'h8000_0304, 0, 0, 0, 1, 1);
        add(0, 64'h0,         0, 0, 1, 0, 0);
        // DROP held across a second flush with no in_valid
        add(0, 64'h0,         1, 1, 0, 0, 0);
        add(0, 64'h0,         1, 1, 0, 0, 0);
        add(1, 64'h8000_0400, 0, 0, 0, 0, 0);
        add(1, 64'h8000_0404, 0, 0, 1, 1, 1);
        add(0, 64'h0,         0, 0, 1, 0, 0);

        // Reset cycle and the cycle after it
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        check_state("reset_during", '0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_state("reset_after", '0);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

        // Reset mid-operation with flush+pending: reset must win over DROP
        v.fl = 0; v.fp = 0; v.ordy = 0; v.acc = 1;
        v.iv = 1; v.pc = 64'h8000_0500; v.cnt = 1; run(v, 100);
        v.iv = 1; v.pc = 64'h8000_0504; v.cnt = 2; run(v, 101);
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.flush = 1'b1; bus.fetch_pending = 1'b1; bus.out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check_state("rst_mid", '0);
        v.iv = 1; v.pc = 64'h8000_0600; v.fl = 0; v.fp = 0; v.ordy = 0; v.acc = 1; v.cnt = 1;
        run(v, 102);
        v.iv = 0; v.pc = 64'h0; v.ordy = 1; v.acc = 0; v.cnt = 0;
        run(v, 103);

        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
